// File: rtl/fb_read_arbiter.sv
// -----------------------------------------------------------------------------
// fb_read_arbiter
//
// Shares the single read port of the camera frame buffer between the VGA
// display (fixed rate, hard priority) and the OLED pixel fetcher (req/ack,
// best effort). Every issued read is tagged with its owner. The returned pixel
// is registered here and steered to the owner c_fb_lat+1 cycles after the grant.
//
// Ports
//   clk            system clock (50 MHz)
//   rst            synchronous reset, active high
//   vga_req        VGA read request, always served in the same cycle
//   vga_addr       VGA read address
//   vga_pxl        VGA pixel, held until the next vga_vld
//   vga_vld        vga_pxl updated this cycle
//   oled_req       OLED read request, held with oled_addr stable until ack
//   oled_addr      OLED read address
//   oled_ack       OLED request accepted this cycle (combinational grant)
//   oled_pxl       OLED pixel, held until the next oled_vld
//   oled_vld       oled_pxl updated this cycle
//   fb_addr        frame buffer read address (addrb)
//   fb_dout        frame buffer read data (doutb)
//   oled_starved   sticky: the OLED waited more than c_max_wait cycles
//   oled_max_wait  largest OLED wait seen (saturating at 255)
//
// Configuration macro
//   FB_ARB_STATS_EN  when defined, oled_max_wait is a register that tracks the
//                    longest OLED wait; when undefined it is tied to zero.
// -----------------------------------------------------------------------------
module fb_read_arbiter #(
  parameter int c_img_cols    = 160,
  parameter int c_img_rows    = 120,
  parameter int c_img_pxls    = c_img_cols * c_img_rows,
  parameter int c_nb_img_pxls = 15,
  parameter int c_nb_buf      = 12,
  parameter int c_fb_lat      = 1,
  parameter int c_max_wait    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vga_req,
  input  logic [c_nb_img_pxls-1:0] vga_addr,
  output logic [c_nb_buf-1:0]      vga_pxl,
  output logic                     vga_vld,
  input  logic                     oled_req,
  input  logic [c_nb_img_pxls-1:0] oled_addr,
  output logic                     oled_ack,
  output logic [c_nb_buf-1:0]      oled_pxl,
  output logic                     oled_vld,
  output logic [c_nb_img_pxls-1:0] fb_addr,
  input  logic [c_nb_buf-1:0]      fb_dout,
  output logic                     oled_starved,
  output logic [7:0]               oled_max_wait
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_OLED = 2'd2
  } owner_t;

  // One entry per read in flight; oor marks an address outside the image.
  typedef struct packed {
    owner_t owner;
    logic   oor;
  } tag_t;

  localparam logic [c_nb_img_pxls-1:0] lp_img_pxls = c_nb_img_pxls'(c_img_pxls);
  localparam logic [7:0]               lp_max_wait = 8'(c_max_wait);

  // ---------------------------------------------------------------------------
  // Grant and address selection
  // ---------------------------------------------------------------------------
  logic                     w_vga_grant;
  logic                     w_oled_grant;
  logic [c_nb_img_pxls-1:0] w_sel_addr;
  logic                     w_sel_oor;
  logic [c_nb_img_pxls-1:0] w_fb_addr;
  tag_t                     w_new_tag;

  logic [c_nb_img_pxls-1:0] r_fb_addr;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_vga_grant  = 1'b0;
    w_oled_grant = 1'b0;
    w_sel_addr   = vga_addr;
    // Nothing is granted while in reset, so no read can be issued then.
    if (!rst) begin
      if (vga_req) begin
        w_vga_grant = 1'b1;
      end else if (oled_req) begin
        w_oled_grant = 1'b1;
        w_sel_addr   = oled_addr;
      end
    end

    w_sel_oor = (w_sel_addr >= lp_img_pxls);

    w_new_tag = '{owner: OWN_NONE, oor: 1'b0};
    if (w_vga_grant) begin
      w_new_tag.owner = OWN_VGA;
      w_new_tag.oor   = w_sel_oor;
    end else if (w_oled_grant) begin
      w_new_tag.owner = OWN_OLED;
      w_new_tag.oor   = w_sel_oor;
    end

    // The frame buffer never sees an out-of-range address: the port keeps
    // pointing at the last legal one and the tag zeroes the returned pixel.
    w_fb_addr = r_fb_addr;
    if ((w_vga_grant || w_oled_grant) && !w_sel_oor) begin
      w_fb_addr = w_sel_addr;
    end
  end

  // The address goes straight to the buffer in the grant cycle so that its
  // read latency starts counting there; r_fb_addr only remembers it for idle.
  assign fb_addr  = w_fb_addr;
  assign oled_ack = w_oled_grant;

  // ---------------------------------------------------------------------------
  // Tag pipeline and return registers
  // ---------------------------------------------------------------------------
  tag_t [c_fb_lat-1:0] r_tag;
  tag_t                w_ret_tag;
  logic [c_nb_buf-1:0] w_ret_pxl;

  logic [c_nb_buf-1:0] r_vga_pxl;
  logic                r_vga_vld;
  logic [c_nb_buf-1:0] r_oled_pxl;
  logic                r_oled_vld;

  // The last stage lines up with the buffer data for the same read.
  assign w_ret_tag = r_tag[c_fb_lat-1];
  assign w_ret_pxl = w_ret_tag.oor ? '0 : fb_dout;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its sources (the shift loop below
  // depends on that to move each stage by exactly one position).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fb_addr  <= '0;
      r_tag      <= '0;
      r_vga_pxl  <= '0;
      r_vga_vld  <= 1'b0;
      r_oled_pxl <= '0;
      r_oled_vld <= 1'b0;
    end else begin
      r_fb_addr <= w_fb_addr;

      r_tag[0] <= w_new_tag;
      for (int i = 1; i < c_fb_lat; i++) begin
        r_tag[i] <= r_tag[i-1];
      end

      r_vga_vld  <= (w_ret_tag.owner == OWN_VGA);
      r_oled_vld <= (w_ret_tag.owner == OWN_OLED);
      if (w_ret_tag.owner == OWN_VGA) begin
        r_vga_pxl <= w_ret_pxl;
      end
      if (w_ret_tag.owner == OWN_OLED) begin
        r_oled_pxl <= w_ret_pxl;
      end
    end
  end

  assign vga_pxl  = r_vga_pxl;
  assign vga_vld  = r_vga_vld;
  assign oled_pxl = r_oled_pxl;
  assign oled_vld = r_oled_vld;

  // ---------------------------------------------------------------------------
  // OLED wait counter and starvation flag
  // ---------------------------------------------------------------------------
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_next;
  logic       r_starved;

  // Counts consecutive cycles of an unanswered request; an ack or a withdrawn
  // request both restart it from zero.
  always_comb begin
    w_wait_next = 8'd0;
    if (oled_req && !w_oled_grant) begin
      w_wait_next = (r_wait_cnt == 8'hFF) ? 8'hFF : r_wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= 8'd0;
      r_starved  <= 1'b0;
    end else begin
      r_wait_cnt <= w_wait_next;
      // Judged on the next count so the flag rises together with it.
      if (w_wait_next > lp_max_wait) begin
        r_starved <= 1'b1;
      end
    end
  end

  assign oled_starved = r_starved;

`ifdef FB_ARB_STATS_EN
  logic [7:0] r_max_wait;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_max_wait <= 8'd0;
    end else if (w_wait_next > r_max_wait) begin
      r_max_wait <= w_wait_next;
    end
  end

  assign oled_max_wait = r_max_wait;
`else
  assign oled_max_wait = 8'd0;
`endif

endmodule

// File: tb/tb_fb_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_read_arbiter
//
// Self-checking bench for fb_read_arbiter: a stimulus table, directed
// multi-cycle sequences, and randomized traffic, all compared each cycle
// against a queue-based model of the arbitration rules. The frame buffer is a
// random-filled array behind a c_fb_lat-deep read pipeline.
// -----------------------------------------------------------------------------
module tb_fb_read_arbiter;

  localparam int LAT  = 1;
  localparam int MAXW = 8;
  localparam int PXLS = 19200;
  localparam int AW   = 15;
  localparam int DW   = 12;

`ifdef FB_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vga_req = 1'b0;
  logic [AW-1:0] vga_addr = '0;
  logic [DW-1:0] vga_pxl;
  logic          vga_vld;
  logic          oled_req = 1'b0;
  logic [AW-1:0] oled_addr = '0;
  logic          oled_ack;
  logic [DW-1:0] oled_pxl;
  logic          oled_vld;
  logic [AW-1:0] fb_addr;
  logic [DW-1:0] fb_dout;
  logic          oled_starved;
  logic [7:0]    oled_max_wait;

  always #5 clk = ~clk;

  fb_read_arbiter #(
    .c_img_cols    (160),
    .c_img_rows    (120),
    .c_nb_img_pxls (AW),
    .c_nb_buf      (DW),
    .c_fb_lat      (LAT),
    .c_max_wait    (MAXW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .vga_req       (vga_req),
    .vga_addr      (vga_addr),
    .vga_pxl       (vga_pxl),
    .vga_vld       (vga_vld),
    .oled_req      (oled_req),
    .oled_addr     (oled_addr),
    .oled_ack      (oled_ack),
    .oled_pxl      (oled_pxl),
    .oled_vld      (oled_vld),
    .fb_addr       (fb_addr),
    .fb_dout       (fb_dout),
    .oled_starved  (oled_starved),
    .oled_max_wait (oled_max_wait)
  );

  // Frame buffer model: LAT-cycle read pipeline over random contents.
  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] fb_pipe [LAT];

  always @(posedge clk) begin
    fb_pipe[0] <= mem[fb_addr];
    for (int i = 1; i < LAT; i++) fb_pipe[i] <= fb_pipe[i-1];
  end
  assign fb_dout = fb_pipe[LAT-1];

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  typedef struct {
    int            due;
    bit            is_oled;
    logic [DW-1:0] pxl;
  } ret_t;

  ret_t          q[$];
  int            cyc;
  bit            m_vvld, m_ovld, m_starved;
  logic [DW-1:0] m_vpxl, m_opxl;
  int            m_wait, m_max, m_last;
  bit            chk_en;

  // Outputs captured in the most recent cycle.
  logic          obs_ack, obs_vvld, obs_ovld, obs_starved;
  logic [DW-1:0] obs_vpxl, obs_opxl;
  logic [AW-1:0] obs_fb;
  logic [7:0]    obs_max;

  int n_tests;
  int n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive, compare with the model mid-cycle, then advance
  // the model across the rising edge.
  task automatic cycle(input bit r, input bit vr, input int va, input bit orq, input int oa);
    int   addr;
    bit   oor;
    bit   exp_ack;
    int   exp_fb;
    ret_t e;
    rst       = r;
    vga_req   = vr;
    vga_addr  = AW'(va);
    oled_req  = orq;
    oled_addr = AW'(oa);
    @(negedge clk);
    obs_ack     = oled_ack;
    obs_fb      = fb_addr;
    obs_vvld    = vga_vld;
    obs_ovld    = oled_vld;
    obs_vpxl    = vga_pxl;
    obs_opxl    = oled_pxl;
    obs_starved = oled_starved;
    obs_max     = oled_max_wait;

    addr    = vr ? va : oa;
    oor     = (addr >= PXLS);
    exp_ack = !r && !vr && orq;
    exp_fb  = (!r && (vr || orq) && !oor) ? addr : m_last;
    if (chk_en) begin
      check("oled_ack", 32'(obs_ack), 32'(exp_ack));
      check("fb_addr", 32'(obs_fb), 32'(exp_fb));
      check("vga_vld", 32'(obs_vvld), 32'(m_vvld));
      check("oled_vld", 32'(obs_ovld), 32'(m_ovld));
      check("vga_pxl", 32'(obs_vpxl), 32'(m_vpxl));
      check("oled_pxl", 32'(obs_opxl), 32'(m_opxl));
      check("oled_starved", 32'(obs_starved), 32'(m_starved));
      check("oled_max_wait", 32'(obs_max), 32'(m_max));
    end

    @(posedge clk);
    if (r) begin
      q.delete();
      m_vvld = 0; m_ovld = 0; m_vpxl = '0; m_opxl = '0;
      m_wait = 0; m_starved = 0; m_max = 0; m_last = 0;
    end else begin
      if (vr || orq) begin
        e.due     = cyc + LAT + 1;
        e.is_oled = !vr;
        e.pxl     = oor ? '0 : mem[addr];
        q.push_back(e);
        if (!oor) m_last = addr;
      end
      m_wait = (orq && vr) ? ((m_wait < 255) ? m_wait + 1 : 255) : 0;
      if (m_wait > MAXW) m_starved = 1;
      if (STATS && m_wait > m_max) m_max = m_wait;
      m_vvld = 0;
      m_ovld = 0;
      if (q.size() > 0 && q[0].due == cyc + 1) begin
        e = q.pop_front();
        if (e.is_oled) begin m_ovld = 1; m_opxl = e.pxl; end
        else begin m_vvld = 1; m_vpxl = e.pxl; end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
  endtask

  function automatic int rand_addr();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(PXLS, (1 << AW) - 1));
    return int'($urandom_range(0, PXLS - 1));
  endfunction

  // Stimulus table: applied back to back right after reset (last address 0).
  typedef struct {
    bit            vreq;
    int            vaddr;
    bit            oreq;
    int            oaddr;
    bit            exp_ack;
    logic [AW-1:0] exp_fb;
  } vec_t;

  vec_t vecs[8];

  bit pend;
  int pend_addr;
  bit rr, vr;
  int load;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    m_vvld = 0; m_ovld = 0; m_vpxl = '0; m_opxl = '0;
    m_wait = 0; m_starved = 0; m_max = 0; m_last = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom_range(1, (1 << DW) - 1));

    vecs[0] = '{1'b1, 5,     1'b0, 0,     1'b0, 15'd5};
    vecs[1] = '{1'b0, 0,     1'b1, 7,     1'b1, 15'd7};
    vecs[2] = '{1'b1, 9,     1'b1, 7,     1'b0, 15'd9};
    vecs[3] = '{1'b0, 0,     1'b0, 0,     1'b0, 15'd9};
    vecs[4] = '{1'b1, 19200, 1'b0, 0,     1'b0, 15'd9};
    vecs[5] = '{1'b0, 0,     1'b1, 20000, 1'b1, 15'd9};
    vecs[6] = '{1'b0, 0,     1'b1, 19199, 1'b1, 15'd19199};
    vecs[7] = '{1'b1, 0,     1'b1, 4,     1'b0, 15'd0};

    // Power-up reset: outputs are unknown until the first reset edge.
    chk_en = 0;
    cycle(1, 0, 0, 0, 0);
    chk_en = 1;
    cycle(1, 0, 0, 0, 0);

    // Reset state.
    idle();
    check("rst_vga_vld", 32'(obs_vvld), 32'd0);
    check("rst_oled_vld", 32'(obs_ovld), 32'd0);
    check("rst_vga_pxl", 32'(obs_vpxl), 32'd0);
    check("rst_oled_pxl", 32'(obs_opxl), 32'd0);
    check("rst_starved", 32'(obs_starved), 32'd0);
    check("rst_fb_addr", 32'(obs_fb), 32'd0);

    // Grant table.
    foreach (vecs[i]) begin
      cycle(0, vecs[i].vreq, vecs[i].vaddr, vecs[i].oreq, vecs[i].oaddr);
      check("tbl_ack", 32'(obs_ack), 32'(vecs[i].exp_ack));
      check("tbl_fb_addr", 32'(obs_fb), 32'(vecs[i].exp_fb));
    end
    repeat (4) idle();

    // VGA alone: reads 0,1,2 return in cycles 2,3,4.
    do_reset();
    cycle(0, 1, 0, 0, 0);
    check("t1_c0_vld", 32'(obs_vvld), 32'd0);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 2, 0, 0);
    check("t1_c2_vld", 32'(obs_vvld), 32'd1);
    check("t1_c2_pxl", 32'(obs_vpxl), 32'(mem[0]));
    idle();
    check("t1_c3_pxl", 32'(obs_vpxl), 32'(mem[1]));
    idle();
    check("t1_c4_pxl", 32'(obs_vpxl), 32'(mem[2]));
    check("t1_oled_vld", 32'(obs_ovld), 32'd0);
    idle();
    check("t1_c5_vld", 32'(obs_vvld), 32'd0);
    check("t1_c5_hold", 32'(obs_vpxl), 32'(mem[2]));

    // Interleave: OLED slips into the first VGA-free cycle.
    do_reset();
    cycle(0, 1, 10, 1, 100);
    check("t2_c0_ack", 32'(obs_ack), 32'd0);
    cycle(0, 0, 0, 1, 100);
    check("t2_c1_ack", 32'(obs_ack), 32'd1);
    cycle(0, 1, 11, 0, 0);
    check("t2_c2_vpxl", 32'(obs_vpxl), 32'(mem[10]));
    idle();
    check("t2_c3_ovld", 32'(obs_ovld), 32'd1);
    check("t2_c3_opxl", 32'(obs_opxl), 32'(mem[100]));
    cycle(0, 1, 12, 0, 0);
    check("t2_c4_vpxl", 32'(obs_vpxl), 32'(mem[11]));
    idle();
    idle();
    check("t2_c6_vpxl", 32'(obs_vpxl), 32'(mem[12]));

    // Collision: ten cycles of VGA load starve the OLED.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cycle(0, 1, k, 1, 50);
      check("t3_ack", 32'(obs_ack), 32'd0);
      check("t3_starved", 32'(obs_starved), (k >= 9) ? 32'd1 : 32'd0);
    end
    cycle(0, 0, 0, 1, 50);
    check("t3_ack_late", 32'(obs_ack), 32'd1);
    check("t3_starved_hold", 32'(obs_starved), 32'd1);
    check("t3_max_wait", 32'(obs_max), STATS ? 32'd10 : 32'd0);
    idle();
    check("t3_starved_idle", 32'(obs_starved), 32'd1);

    // Reset mid-flight: the OLED read granted just before rst never returns.
    cycle(0, 0, 0, 1, 30);
    check("t5_ack", 32'(obs_ack), 32'd1);
    check("t5_prev_opxl", 32'(obs_opxl), 32'(mem[50]));
    cycle(1, 0, 0, 0, 0);
    idle();
    check("t5_ovld", 32'(obs_ovld), 32'd0);
    check("t5_opxl", 32'(obs_opxl), 32'd0);
    check("t5_vpxl", 32'(obs_vpxl), 32'd0);
    check("t5_starved", 32'(obs_starved), 32'd0);
    check("t5_max", 32'(obs_max), 32'd0);
    check("t5_fb_addr", 32'(obs_fb), 32'd0);
    idle();
    check("t5_ovld_late", 32'(obs_ovld), 32'd0);

    // Out of range: 19200 is never driven and returns zero.
    cycle(0, 1, 19200, 0, 0);
    check("t4_fb_oor", 32'(obs_fb), 32'd0);
    cycle(0, 1, 19199, 0, 0);
    check("t4_fb_last", 32'(obs_fb), 32'd19199);
    idle();
    check("t4_vld0", 32'(obs_vvld), 32'd1);
    check("t4_pxl0", 32'(obs_vpxl), 32'd0);
    idle();
    check("t4_pxl1", 32'(obs_vpxl), 32'(mem[19199]));

    // Withdrawn request: the wait count restarts from zero.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, k, 1, 40);
      check("t6_ack", 32'(obs_ack), 32'd0);
    end
    for (int k = 0; k < 3; k++) begin
      idle();
      check("t6_ovld", 32'(obs_ovld), 32'd0);
    end
    for (int k = 0; k < 8; k++) begin
      cycle(0, 1, k, 1, 41);
      check("t6_starved", 32'(obs_starved), 32'd0);
    end
    idle();
    check("t6_starved_end", 32'(obs_starved), 32'd0);
    check("t6_max", 32'(obs_max), STATS ? 32'd8 : 32'd0);

    // Randomized traffic against the model.
    do_reset();
    pend      = 0;
    pend_addr = 0;
    for (int k = 0; k < 3000; k++) begin
      if (k < 800) load = 30;
      else if (k < 1600) load = 70;
      else if (k < 2100) load = 100;
      else load = 50;
      rr = (load < 100) && ($urandom_range(0, 199) == 0);
      vr = ($urandom_range(0, 99) < load);
      if (!pend && $urandom_range(0, 3) == 0) begin
        pend      = 1;
        pend_addr = rand_addr();
      end else if (pend && load < 100 && $urandom_range(0, 29) == 0) begin
        pend = 0;
      end
      cycle(rr, vr, rand_addr(), pend, pend_addr);
      if (rr || !vr) pend = 0;
    end
    repeat (4) idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
